// File: rtl/sm_mult_sequencer.sv
// Sequential sign-magnitude multiplier: N-step shift-add on one shared N-bit adder,
// followed by a sign-apply stage that yields a two's complement product.
module sm_mult_sequencer #(
  parameter int N = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a_mag,
  input  logic           a_sign,
  input  logic [N-1:0]   b_mag,
  input  logic           b_sign,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   product
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    CONV,
    DONE
  } state_t;

  state_t          state, state_next;
  logic [N-1:0]    acc;
  logic [N-1:0]    mplier;
  logic [N-1:0]    mcand;
  logic            sign_r;
  logic [CW-1:0]   cnt;

  logic [N-1:0]    addend;
  logic [N:0]      sum;
  logic [2*N:0]    mag;
  logic            accept;

  // The edge that leaves DONE is the return to IDLE, so a held start is taken
  // there directly; that keeps back-to-back throughput at one op per N+2 cycles.
  assign accept = start && (state == IDLE || state == DONE);

  assign addend = mplier[0] ? mcand : '0;
  assign sum    = {1'b0, acc} + {1'b0, addend};
  assign mag    = {1'b0, acc, mplier};

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values, independent of block ordering.
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next
    // unassigned, which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = MULT;
      MULT: if (cnt == CNT_LAST) state_next = CONV;
      CONV: state_next = DONE;
      DONE: state_next = start ? MULT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every datapath register is cleared so an aborted op leaves no
      // residue and product reads zero straight out of reset.
      acc     <= '0;
      mplier  <= '0;
      mcand   <= '0;
      sign_r  <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      sign_r <= a_sign ^ b_sign;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == MULT) begin
      // {acc, mplier} <= {sum, mplier} >> 1
      acc    <= sum[N:1];
      mplier <= {sum[0], mplier[N-1:1]};
      cnt    <= cnt + 1'b1;
    end else if (state == CONV) begin
      // Negative zero wraps to zero through the +1.
      product <= (mag ^ {(2*N+1){sign_r}}) + {{(2*N){1'b0}}, sign_r};
    end
  end

endmodule

// File: tb/tb_sm_mult_sequencer.sv
// Self-checking bench for sm_mult_sequencer: cycle-level reference model plus
// directed operand vectors with hand-computed products.
module tb_sm_mult_sequencer;

  localparam int N  = 5;
  localparam int PW = 2 * N + 1;
  localparam int LAT = N + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  a_mag = '0;
  logic          a_sign = 1'b0;
  logic [N-1:0]  b_mag = '0;
  logic          b_sign = 1'b0;
  logic          busy;
  logic          done;
  logic [PW-1:0] product;

  int checks = 0;
  int errors = 0;

  sm_mult_sequencer #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_mag   (a_mag),
    .a_sign  (a_sign),
    .b_mag   (b_mag),
    .b_sign  (b_sign),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] signed_product(input int am, input bit as_, input int bm, input bit bs_);
    int          v;
    logic [31:0] t;
    v = (as_ ? -am : am) * (bs_ ? -bm : bm);
    t = v;
    return t[PW-1:0];
  endfunction

  // Reference model: an op is "age" cycles old; age 0 means no op in flight.
  // Start is honoured when idle or in the final (done) cycle of the previous op.
  int            m_age = 0;
  logic [PW-1:0] m_pending = '0;
  logic [PW-1:0] m_product = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age     = 0;
      m_pending = '0;
      m_product = '0;
    end else begin
      if (m_age == LAT - 1) m_product = m_pending;
      if ((m_age == 0 || m_age == LAT) && start) begin
        m_pending = signed_product(int'(a_mag), a_sign, int'(b_mag), b_sign);
        m_age     = 1;
      end else if (m_age == LAT) begin
        m_age = 0;
      end else if (m_age > 0) begin
        m_age = m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy",    32'(busy),    32'(m_age != 0));
    check("done",    32'(done),    32'(m_age == LAT));
    check("product", 32'(product), 32'(m_product));
  end

  // Starts one op from idle; optional pokes of start at op cycles 2 and 4.
  task automatic run_op(input int am, input bit as_, input int bm, input bit bs_,
                        input logic [PW-1:0] exp_lit, input bit poke, input string name);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a_mag = N'(am); a_sign = as_; b_mag = N'(bm); b_sign = bs_;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      start = poke && (k == 2 || k == 4);
      if (k == 1) begin
        a_mag = '0; b_mag = '0; a_sign = 1'b0; b_sign = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        check({name, "_latency"}, 32'(k), 32'(LAT));
        check({name, "_product"}, 32'(product), 32'(exp_lit));
      end
    end
    start = 1'b0;
    if (!seen) check({name, "_done_timeout"}, 32'(0), 32'(1));
  endtask

  logic [PW-1:0] held_exp [3];
  int            done_cnt;

  initial begin
    held_exp[0] = 11'h03F;
    held_exp[1] = 11'h7C4;
    held_exp[2] = 11'h3C1;

    repeat (2) @(negedge clk);
    check("reset_busy",    32'(busy),    32'(0));
    check("reset_done",    32'(done),    32'(0));
    check("reset_product", 32'(product), 32'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_product", 32'(product), 32'(0));

    run_op(13, 0, 11, 0, 11'h08F, 0, "pp");
    run_op(13, 1, 11, 0, 11'h771, 0, "np");
    run_op(13, 0, 11, 1, 11'h771, 0, "pn");
    run_op(13, 1, 11, 1, 11'h08F, 0, "nn");
    run_op(31, 1, 31, 0, 11'h43F, 0, "max_neg");
    run_op(31, 0, 31, 0, 11'h3C1, 0, "max_pos");
    run_op(0,  1, 17, 0, 11'h000, 0, "neg_zero_a");
    run_op(0,  0, 0,  1, 11'h000, 0, "neg_zero_b");
    run_op(6,  0, 5,  1, 11'h7E2, 1, "poked");
    repeat (2) @(negedge clk);
    check("poke_no_queue_busy", 32'(busy), 32'(0));

    // Start held high for three back-to-back ops.
    @(negedge clk);
    a_mag = 5'd7; a_sign = 1'b0; b_mag = 5'd9; b_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    done_cnt = 0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_mag = 5'd20; a_sign = 1'b1; b_mag = 5'd3; b_sign = 1'b0;
      end
      if (k == LAT + 1) begin
        a_mag = 5'd31; a_sign = 1'b1; b_mag = 5'd31; b_sign = 1'b1;
      end
      if (done) begin
        check("held_done_spacing", 32'(k), 32'((done_cnt + 1) * LAT));
        if (done_cnt < 3) check("held_product", 32'(product), 32'(held_exp[done_cnt]));
        done_cnt++;
      end
      if (k == 3 * LAT) start = 1'b0;
    end
    check("held_done_count", 32'(done_cnt), 32'(3));

    // Abort during MULT with cnt=2.
    @(negedge clk);
    a_mag = 5'd9; a_sign = 1'b0; b_mag = 5'd9; b_sign = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy",    32'(busy),    32'(0));
    check("abort_done",    32'(done),    32'(0));
    check("abort_product", 32'(product), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3, 0, 2, 1, 11'h7FA, 0, "after_reset");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
